// File: rtl/qif_pkg.sv
// Shared constants, FSM state type and helpers for the QIF neuron array.
package qif_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_N_CH       = 4;
  localparam int unsigned DEF_FRAC_SHIFT = 3;
  localparam int unsigned DEF_IN_SHIFT   = 2;
  localparam int          DEF_V_RESET    = -20;
  localparam int          DEF_V_TH       = 50;
  localparam int unsigned DEF_REFRAC     = 2;
  localparam int unsigned DEF_EV_DEPTH   = 4;

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/qif_update_core.sv
// Combinational QIF update for one channel: V, acc, refractory -> next state + spike.
module qif_update_core
  import qif_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int unsigned IN_SHIFT   = DEF_IN_SHIFT,
  parameter int          V_RESET    = DEF_V_RESET,
  parameter int          V_TH       = DEF_V_TH,
  parameter int unsigned REFRAC     = DEF_REFRAC,
  parameter int unsigned RW         = 2
) (
  input  logic signed [WIDTH-1:0] v,
  input  logic signed [WIDTH-1:0] acc,
  input  logic        [RW-1:0]    refrac,
  output logic signed [WIDTH-1:0] v_next,
  output logic        [RW-1:0]    refrac_next,
  output logic                    spike
);

  localparam int unsigned SW = 2 * WIDTH + 2;
  localparam logic signed [WIDTH-1:0] VRST = WIDTH'(V_RESET);
  localparam logic signed [WIDTH-1:0] VTH  = WIDTH'(V_TH);

  logic signed [WIDTH-1:0] q;
  logic signed [WIDTH-1:0] acc_in;
  logic signed [SW-1:0]    sum;
  logic signed [WIDTH-1:0] vn;

  assign q      = v >>> FRAC_SHIFT;
  assign acc_in = acc >>> IN_SHIFT;
  assign sum    = SW'(v) + SW'(q) * SW'(q) + SW'(acc_in);
  assign vn     = WIDTH'(sat_s(64'(sum), WIDTH));

  // Refractory hold, threshold test and reset-on-spike.
  always_comb begin
    v_next      = vn;
    refrac_next = refrac;
    spike       = 1'b0;
    if (refrac != '0) begin
      v_next      = VRST;
      refrac_next = refrac - RW'(1);
    end else if (vn >= VTH) begin
      v_next      = VRST;
      refrac_next = RW'(REFRAC);
      spike       = 1'b1;
    end
  end

endmodule

// File: rtl/qif_neuron_array.sv
// Time-multiplexed QIF neuron array: per-channel state, one shared update core,
// IDLE/SWEEP sequencer and a spike-event FIFO with valid/ready output.
module qif_neuron_array
  import qif_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned N_CH       = DEF_N_CH,
  parameter int unsigned FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int unsigned IN_SHIFT   = DEF_IN_SHIFT,
  parameter int          V_RESET    = DEF_V_RESET,
  parameter int          V_TH       = DEF_V_TH,
  parameter int unsigned REFRAC     = DEF_REFRAC,
  parameter int unsigned EV_DEPTH   = DEF_EV_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          in_valid,
  input  logic [ch_w(N_CH)-1:0]         in_ch,
  input  logic signed [WIDTH-1:0]       in_current,
  output logic                          in_ready,
  output logic                          spk_valid,
  input  logic                          spk_ready,
  output logic [ch_w(N_CH)-1:0]         spk_ch,
  output logic                          busy,
  input  logic [ch_w(N_CH)-1:0]         v_mon_ch,
  output logic signed [WIDTH-1:0]       v_mon,
  output logic                          ev_drop,
  output logic                          tick_overrun
);

  localparam int unsigned CW   = ch_w(N_CH);
  localparam int unsigned RW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int unsigned AW   = $clog2(EV_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam logic signed [WIDTH-1:0] VRST = WIDTH'(V_RESET);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  state_t state;
  logic [CW-1:0] ch;

  logic signed [WIDTH-1:0] v      [N_CH];
  logic signed [WIDTH-1:0] acc    [N_CH];
  logic        [RW-1:0]    refrac [N_CH];

  logic signed [WIDTH-1:0] acc_sum;
  logic signed [WIDTH-1:0] core_v;
  logic        [RW-1:0]    core_r;
  logic                    core_spike;

  logic [CW-1:0]   ev_mem [EV_DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CNTW-1:0] count;
  logic            full;
  logic            push;
  logic            pop;
  logic            do_write;

  assign in_ready = ~busy;
  assign v_mon    = v[v_mon_ch];
  assign acc_sum  = WIDTH'(sat_s(64'(acc[in_ch]) + 64'(in_current), WIDTH));

  qif_update_core #(
    .WIDTH      (WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT),
    .IN_SHIFT   (IN_SHIFT),
    .V_RESET    (V_RESET),
    .V_TH       (V_TH),
    .REFRAC     (REFRAC),
    .RW         (RW)
  ) u_core (
    .v           (v[ch]),
    .acc         (acc[ch]),
    .refrac      (refrac[ch]),
    .v_next      (core_v),
    .refrac_next (core_r),
    .spike       (core_spike)
  );

  // Sweep sequencer: one channel per cycle, busy and overrun flag registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ch           <= '0;
      busy         <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_SWEEP;
            ch    <= '0;
            busy  <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (tick) tick_overrun <= 1'b1;
          if (ch == LAST_CH) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            ch    <= '0;
          end else begin
            ch <= ch + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-channel state: saturating current writes while idle, write-back while sweeping.
  // Writes are only accepted when not busy, so they never collide with the sweep's acc clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        v[i]      <= VRST;
        acc[i]    <= '0;
        refrac[i] <= '0;
      end
    end else begin
      if (in_valid && in_ready) acc[in_ch] <= acc_sum;
      if (state == S_SWEEP) begin
        v[ch]      <= core_v;
        acc[ch]    <= '0;
        refrac[ch] <= core_r;
      end
    end
  end

  assign full      = (count == CNTW'(EV_DEPTH));
  assign spk_valid = (count != '0);
  assign spk_ch    = ev_mem[rptr];
  assign push      = (state == S_SWEEP) && core_spike;
  assign pop       = spk_valid && spk_ready;
  // When full, a simultaneous pop frees the head slot, which is the slot wptr points at.
  assign do_write  = push && (!full || pop);

  // Spike-event FIFO with drop detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ev_drop <= 1'b0;
    end else begin
      if (do_write) begin
        ev_mem[wptr] <= ch;
        wptr         <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (push && full && !pop) ev_drop <= 1'b1;
      case ({do_write, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
